// File: rtl/mem_writer.sv
// Stream-to-RAM loader: fills a DEPTH x DATA_W synchronous RAM from a valid/ready
// word stream starting at a programmable base address, with a 1-cycle registered read port.
module mem_writer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   len_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               accept_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic [CNT_W-1:0]   count_inc_c;

    // Handshake/status flags decode straight from the state register.
    assign wr_ready    = (state == LOAD);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // A word is taken only in LOAD and never during a reset cycle.
    assign accept_c    = rst_n && wr_valid && wr_ready;
    assign wr_addr_c   = ADDR_W'(base_q + wr_count[ADDR_W-1:0]);
    assign count_inc_c = CNT_W'(wr_count + CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_count <= '0;
            base_q   <= '0;
            len_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= len;
                        wr_count <= '0;
                        state    <= (len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        wr_count <= count_inc_c;
                        if (count_inc_c == len_q) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM array is deliberately not reset; contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_addr_c] <= wr_data;
        end
    end

    // Read-before-write: a same-cycle write to rd_addr is seen on the next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: stimulus pushes expected reads/done counts,
// a negedge monitor pops and compares; RAM modelled as a plain array.
module tb_mem_writer;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    mem_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy),
        .done(done), .wr_count(wr_count), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_rd[$];
    int exp_done[$];
    int model[DEPTH];
    int wd[DEPTH];
    bit rd_track   = 1'b0;
    bit track_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: read data one cycle after a tracked read, done pulses in order.
    always @(negedge clk) begin
        if (track_prev) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", int'(rd_data), exp_rd.pop_front());
        end
        track_prev = rd_track;
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_count", int'(wr_count), exp_done.pop_front());
        end
    end

    task automatic rd_seq(input int a, input int n);
        for (int i = 0; i < n; i++) begin
            rd_en    = 1'b1;
            rd_addr  = ADDR_W'((a + i) % DEPTH);
            rd_track = 1'b1;
            exp_rd.push_back(model[(a + i) % DEPTH]);
            tick();
        end
        rd_en    = 1'b0;
        rd_track = 1'b1;
        exp_rd.push_back(0);
        tick();
        rd_track = 1'b0;
    endtask

    // One burst; abort_at>0 resets after that many accepts, ign holds start high while busy.
    task automatic burst(input int base, input int n, input int gap_pct,
                         input int abort_at, input bit ign, input bit fixed);
        int acc = 0;
        bit sent;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        len       = (ADDR_W + 1)'(n);
        if (abort_at == 0) exp_done.push_back(n);
        tick();
        start = ign;
        if (ign) begin
            base_addr = ADDR_W'($urandom);
            len       = (ADDR_W + 1)'($urandom_range(1, DEPTH));
        end
        while (acc < n) begin
            if (abort_at != 0 && acc == abort_at) begin
                wr_valid = 1'b0;
                rst_n    = 1'b0;
                tick();
                rst_n = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0);
                chk("abort_ready", int'(wr_ready), 0);
                chk("abort_count", int'(wr_count), 0);
                tick();
                return;
            end
            sent = ($urandom_range(99) >= gap_pct);
            wr_valid = sent;
            wr_data  = fixed ? DATA_W'(wd[acc]) : DATA_W'($urandom);
            @(negedge clk);
            chk("load_ready", int'(wr_ready), 1);
            chk("load_busy", int'(busy), 1);
            chk("load_count", int'(wr_count), acc);
            tick();
            if (sent) begin
                model[(base + acc) % DEPTH] = int'(wr_data);
                acc++;
            end
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("done_busy", int'(busy), 1);
        chk("done_ready", int'(wr_ready), 0);
        chk("done_pulse", int'(done), 1);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_count_hold", int'(wr_count), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(wr_count), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back burst at base 0.
        wd[0] = 2; wd[1] = 2; wd[2] = 14; wd[3] = 2;
        burst(0, 4, 0, 0, 1'b0, 1'b1);
        rd_seq(0, 4);

        // Fill every location so later reads are fully defined.
        burst(0, DEPTH, 20, 0, 1'b0, 1'b0);
        rd_seq(0, DEPTH);

        // Address wrap with valid gaps and start ignored while busy.
        wd[0] = 10; wd[1] = 12; wd[2] = 0; wd[3] = 4;
        burst(14, 4, 50, 0, 1'b1, 1'b1);
        rd_seq(14, 4);

        // Zero-length burst leaves RAM untouched.
        burst(3, 0, 0, 0, 1'b0, 1'b0);
        rd_seq(0, DEPTH);

        // Same-cycle read and write to one address.
        wd[0] = 10;
        burst(5, 1, 0, 0, 1'b0, 1'b1);
        start = 1'b1; base_addr = ADDR_W'(5); len = (ADDR_W + 1)'(1);
        exp_done.push_back(1);
        tick();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = DATA_W'(3);
        rd_en    = 1'b1;
        rd_addr  = ADDR_W'(5);
        rd_track = 1'b1;
        exp_rd.push_back(model[5]);
        tick();
        model[5] = 3;
        wr_valid = 1'b0;
        exp_rd.push_back(model[5]);
        tick();
        rd_en = 1'b0;
        exp_rd.push_back(0);
        tick();
        rd_track = 1'b0;
        tick();

        // Reset mid-burst after three accepts.
        burst(9, 8, 30, 3, 1'b1, 1'b0);
        rd_seq(0, DEPTH);

        for (int k = 0; k < 10; k++) begin
            burst($urandom_range(DEPTH - 1), $urandom_range(DEPTH), 30, 0,
                  1'($urandom_range(1)), 1'b0);
            rd_seq(0, DEPTH);
        end

        tick();
        tick();
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
